// File: rtl/int_unpack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_unpack_pkg
// Description : Shared sizing helpers and FSM states for the INT unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
package int_unpack_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    EMIT  = 1'b1
  } state_e;

  function automatic int elems_per_word(input int in_width, input int int_width);
    return in_width / int_width;
  endfunction

  // Element count 1..N needs one bit more than an index into N elements.
  function automatic int count_width(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int beat_idx_width(input int beats_max);
    return (beats_max > 1) ? $clog2(beats_max) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/int_lane_select.sv
`default_nettype none
// ============================================================================
// Module      : int_lane_select
// Description : Picks the LANES elements of one beat from the held word and
//               zeroes any lane whose element index is at or beyond the count.
// Revision    : 1.0 - initial release
// ============================================================================
module int_lane_select
  import int_unpack_pkg::*;
#(
  parameter int INT_WIDTH = 4,
  parameter int IN_WIDTH  = 32,
  parameter int LANES     = 2,
  parameter int CNT_W     = count_width(elems_per_word(IN_WIDTH, INT_WIDTH)),
  parameter int IDX_W     = beat_idx_width(elems_per_word(IN_WIDTH, INT_WIDTH) / LANES)
) (
  input  logic [IN_WIDTH-1:0]        word_i,
  input  logic [IDX_W-1:0]           beat_idx_i,
  input  logic [CNT_W-1:0]           count_i,
  output logic [LANES*INT_WIDTH-1:0] lanes_o
);

  localparam int c_N = elems_per_word(IN_WIDTH, INT_WIDTH);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [CNT_W-1:0]     w_elem;
    logic [INT_WIDTH-1:0] w_lane;

    always_comb begin
      w_elem = CNT_W'(beat_idx_i) * CNT_W'(LANES) + CNT_W'(k);
      w_lane = '0;
      for (int e = 0; e < c_N; e++) begin
        if ((w_elem == CNT_W'(e)) && (w_elem < count_i)) begin
          w_lane = word_i[e*INT_WIDTH +: INT_WIDTH];
        end
      end
    end

    assign lanes_o[k*INT_WIDTH +: INT_WIDTH] = w_lane;
  end

endmodule
`default_nettype wire

// File: rtl/int_packed_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : int_packed_unpacker
// Description : Holds a packed word of signed INT elements and streams it out
//               LANES elements per beat, LSB element first.
// Revision    : 1.0 - initial release
// ============================================================================
module int_packed_unpacker
  import int_unpack_pkg::*;
#(
  parameter int INT_WIDTH = 4,
  parameter int IN_WIDTH  = 32,
  parameter int LANES     = 2,
  parameter int CNT_W     = count_width(elems_per_word(IN_WIDTH, INT_WIDTH)),
  parameter int IDX_W     = beat_idx_width(elems_per_word(IN_WIDTH, INT_WIDTH) / LANES)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [IN_WIDTH-1:0]        in_data_i,
  input  logic [CNT_W-1:0]           in_count_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [LANES*INT_WIDTH-1:0] out_data_o,
  output logic                       out_last_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i
);

  localparam int c_N = elems_per_word(IN_WIDTH, INT_WIDTH);

  state_e               r_state,    w_state_nxt;
  logic [IN_WIDTH-1:0]  r_word,     w_word_nxt;
  logic [CNT_W-1:0]     r_count,    w_count_nxt;
  logic [IDX_W-1:0]     r_last_idx, w_last_idx_nxt;
  logic [IDX_W-1:0]     r_beat_idx, w_beat_idx_nxt;

  logic [CNT_W-1:0]           w_count_eff;
  logic [CNT_W-1:0]           w_beats;
  logic                       w_beat_fire;
  logic                       w_accept;
  logic [LANES*INT_WIDTH-1:0] w_lanes;

  int_lane_select #(
    .INT_WIDTH (INT_WIDTH),
    .IN_WIDTH  (IN_WIDTH),
    .LANES     (LANES),
    .CNT_W     (CNT_W),
    .IDX_W     (IDX_W)
  ) u_lane_select (
    .word_i     (r_word),
    .beat_idx_i (r_beat_idx),
    .count_i    (r_count),
    .lanes_o    (w_lanes)
  );

  // Outputs depend on registers only, so they hold steady under backpressure.
  assign out_valid_o = (r_state == EMIT);
  assign out_last_o  = (r_state == EMIT) && (r_beat_idx == r_last_idx);
  assign out_data_o  = (r_state == EMIT) ? w_lanes : '0;

  assign w_beat_fire = out_valid_o && out_ready_i;
  assign in_ready_o  = ((r_state == EMPTY) || (w_beat_fire && out_last_o)) && !flush_i;
  assign w_accept    = in_valid_i && in_ready_o;

  assign w_count_eff = (in_count_i == '0) ? CNT_W'(c_N) : in_count_i;
  assign w_beats     = (w_count_eff + CNT_W'(LANES - 1)) / CNT_W'(LANES);

  always_comb begin
    w_state_nxt    = r_state;
    w_word_nxt     = r_word;
    w_count_nxt    = r_count;
    w_last_idx_nxt = r_last_idx;
    w_beat_idx_nxt = r_beat_idx;
    if (flush_i) begin
      w_state_nxt    = EMPTY;
      w_beat_idx_nxt = '0;
    end else if (w_accept) begin
      // Covers both the idle load and the no-bubble reload on a last beat.
      w_state_nxt    = EMIT;
      w_word_nxt     = in_data_i;
      w_count_nxt    = w_count_eff;
      w_last_idx_nxt = IDX_W'(w_beats - CNT_W'(1));
      w_beat_idx_nxt = '0;
    end else if (w_beat_fire) begin
      if (out_last_o) begin
        w_state_nxt    = EMPTY;
        w_beat_idx_nxt = '0;
      end else begin
        w_beat_idx_nxt = r_beat_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= EMPTY;
      r_word     <= '0;
      r_count    <= '0;
      r_last_idx <= '0;
      r_beat_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_word     <= w_word_nxt;
      r_count    <= w_count_nxt;
      r_last_idx <= w_last_idx_nxt;
      r_beat_idx <= w_beat_idx_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int_packed_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_packed_unpacker
// Description : Directed bench for int_packed_unpacker (4/32/2 and 1/8/1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_packed_unpacker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default configuration: INT_WIDTH=4, IN_WIDTH=32, LANES=2
  logic        flush;
  logic [31:0] in_data;
  logic [3:0]  in_count;
  logic        in_valid, in_ready;
  logic [7:0]  out_data;
  logic        out_last, out_valid, out_ready;

  // Narrow configuration: INT_WIDTH=1, IN_WIDTH=8, LANES=1
  logic        b_flush;
  logic [7:0]  b_in_data;
  logic [3:0]  b_in_count;
  logic        b_in_valid, b_in_ready;
  logic [0:0]  b_out_data;
  logic        b_out_last, b_out_valid, b_out_ready;

  int total = 0;
  int bad   = 0;

  int_packed_unpacker #(.INT_WIDTH(4), .IN_WIDTH(32), .LANES(2)) dut_a (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_data_i   (in_data),
    .in_count_i  (in_count),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  int_packed_unpacker #(.INT_WIDTH(1), .IN_WIDTH(8), .LANES(1)) dut_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (b_flush),
    .in_data_i   (b_in_data),
    .in_count_i  (b_in_count),
    .in_valid_i  (b_in_valid),
    .in_ready_o  (b_in_ready),
    .out_data_o  (b_out_data),
    .out_last_o  (b_out_last),
    .out_valid_o (b_out_valid),
    .out_ready_i (b_out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one word for a single accepting edge, then withdraw it.
  task automatic send(input string tag, input logic [31:0] word, input logic [3:0] cnt);
    @(negedge clk);
    in_data  = word;
    in_count = cnt;
    in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [7:0] d, input logic l);
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_last"},  32'(out_last),  32'(l));
  endtask

  logic [7:0] full_exp [4] = '{8'h10, 8'h32, 8'h54, 8'h76};
  logic [7:0] b2b_exp  [8] = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};
  logic       nar_exp  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    flush = 0; in_data = '0; in_count = '0; in_valid = 0; out_ready = 1;
    b_flush = 0; b_in_data = '0; b_in_count = '0; b_in_valid = 0; b_out_ready = 1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    chk("rst_b_valid", 32'(b_out_valid), 32'd0);
    chk("rst_b_ready", 32'(b_in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: full word, count 0 means all eight elements
    @(negedge clk);
    #1 chk("t1_pre_valid", 32'(out_valid), 32'd0);
    send("t1", 32'h76543210, 4'd0);
    for (int i = 0; i < 4; i++) expect_beat("t1", full_exp[i], i == 3);
    @(negedge clk);
    #1;
    chk("t1_idle_valid", 32'(out_valid), 32'd0);
    chk("t1_idle_ready", 32'(in_ready),  32'd1);

    // 2: partial word, lane 1 of the second beat masked
    send("t2", 32'hFFFFF3A1, 4'd3);
    expect_beat("t2_b0", 8'hA1, 1'b0);
    expect_beat("t2_b1", 8'h03, 1'b1);
    @(negedge clk);
    #1 chk("t2_idle_valid", 32'(out_valid), 32'd0);

    // 3: backpressure on beat 0 for five cycles
    send("t3", 32'h76543210, 4'd0);
    expect_beat("t3_b0", 8'h10, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) expect_beat("t3_hold", 8'h10, 1'b0);
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) expect_beat("t3_resume", full_exp[i], i == 3);
    @(negedge clk);
    #1 chk("t3_idle_valid", 32'(out_valid), 32'd0);

    // 4: back-to-back words, reload on the last beat without a bubble
    @(negedge clk);
    in_data = 32'h76543210; in_count = 4'd0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_data = 32'hFEDCBA98;
    for (int i = 0; i < 8; i++) begin
      expect_beat("t4", b2b_exp[i], (i == 3) || (i == 7));
      if (i == 2) chk("t4_busy_ready", 32'(in_ready), 32'd0);
      if (i == 3) begin
        chk("t4_last_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
      end
    end
    @(negedge clk);
    #1 chk("t4_idle_valid", 32'(out_valid), 32'd0);

    // 5a: flush during beat 1 with a competing word offered
    send("t5a", 32'h76543210, 4'd0);
    expect_beat("t5a_b0", 8'h10, 1'b0);
    expect_beat("t5a_b1", 8'h32, 1'b0);
    flush = 1'b1; in_data = 32'h11111111; in_count = 4'd0; in_valid = 1'b1;
    #1 chk("t5a_flush_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 begin flush = 1'b0; in_valid = 1'b0; end
    @(negedge clk);
    #1;
    chk("t5a_valid", 32'(out_valid), 32'd0);
    chk("t5a_ready", 32'(in_ready),  32'd1);
    chk("t5a_data",  32'(out_data),  32'd0);
    @(negedge clk);
    #1 chk("t5a_dropped", 32'(out_valid), 32'd0);

    // 5b: asynchronous reset in the middle of a beat
    send("t5b", 32'h76543210, 4'd0);
    expect_beat("t5b_b0", 8'h10, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5b_async_valid", 32'(out_valid), 32'd0);
    chk("t5b_async_last",  32'(out_last),  32'd0);
    chk("t5b_async_data",  32'(out_data),  32'd0);
    chk("t5b_async_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 chk("t5b_no_stale", 32'(out_valid), 32'd0);
    end
    send("t5b_after", 32'h000000C5, 4'd2);
    expect_beat("t5b_after", 8'hC5, 1'b1);

    // 6: INT_WIDTH=1, LANES=1, four of eight bits valid
    @(negedge clk);
    b_in_data = 8'h05; b_in_count = 4'd4; b_in_valid = 1'b1;
    #1 chk("t6_in_ready", 32'(b_in_ready), 32'd1);
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("t6_valid", 32'(b_out_valid), 32'd1);
      chk("t6_data",  32'(b_out_data),  32'(nar_exp[i]));
      chk("t6_last",  32'(b_out_last),  32'(i == 3));
    end
    @(negedge clk);
    #1 chk("t6_idle_valid", 32'(b_out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/int_packed_unpacker.md
Name: int_packed_unpacker

Overview:
- Upstream feeder for the intN-to-fp16 converter lanes.
- Accepts wide words of packed signed INT_WIDTH elements from the streamer over a valid/ready handshake.
- Holds each word and emits LANES elements per beat, LSB element first, over a second valid/ready handshake.
- Each output lane drives one converter instance directly.

Parameters:
- INT_WIDTH, 4, element width in bits; legal values 1, 2, 3, 4.
- IN_WIDTH, 32, packed input word width; must be a multiple of INT_WIDTH.
- LANES, 2, elements emitted per output beat; N = IN_WIDTH/INT_WIDTH must be a multiple of LANES.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear; drops any held word
- in_data_i  in  IN_WIDTH  packed elements; element e occupies bits [e*INT_WIDTH +: INT_WIDTH]
- in_count_i  in  $clog2(N)+1  number of valid elements in the word, 1..N; 0 means N
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  input word accepted when in_valid_i && in_ready_o
- out_data_o  out  LANES*INT_WIDTH  lane k at [k*INT_WIDTH +: INT_WIDTH]
- out_last_o  out  1  final beat of the current word
- out_valid_o  out  1  beat valid
- out_ready_i  in  1  consumer ready

Behaviour:
- Clock and reset are fixed: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- State registers: two states, EMPTY and EMIT; held word; beat count; beat index.
  - Effective count C = (in_count_i == 0) ? N : in_count_i.
  - beats = ceil(C/LANES), latched when the word is accepted.
- Reset values:
  - state = EMPTY, beat index = 0, held word = 0.
  - out_valid_o = 0, out_last_o = 0, out_data_o = 0.
  - in_ready_o = 1.
- in_ready_o = (state == EMPTY) || (out_valid_o && out_ready_i && out_last_o) && !flush_i.
  - No combinational path from in_valid_i to in_ready_o.
- Accept:
  - On in_valid_i && in_ready_o: latch word and beats; beat index = 0; state = EMIT.
  - First beat is valid in the next cycle, giving 1-cycle latency.
- EMIT:
  - out_valid_o = 1.
  - Lane k of beat b carries element b*LANES+k. Lanes with index >= C are driven 0, which the converter maps to +0.0.
  - out_last_o = (beat index == beats-1).
  - Handshake (out_valid_o && out_ready_i), non-last beat: beat index += 1.
  - Handshake, last beat, and a new word accepted in the same cycle: reload; stay in EMIT with no bubble.
  - Handshake, last beat, no new word: go to EMPTY.
- Backpressure: while out_valid_o && !out_ready_i, out_data_o and out_last_o stay stable. They are functions of registers only.
- Flush: flush_i has priority over every handshake.
  - Next cycle: state = EMPTY, out_valid_o = 0.
  - A word presented in the flush cycle is not accepted.
- Reset mid-word: the held word is discarded; no beat is ever emitted for it.
- Elements are passed through raw (two's complement). Sign handling belongs to the converter.

Decomposition:
- Package int_unpack_pkg holds:
  - function elems_per_word(IN_WIDTH, INT_WIDTH);
  - count-width and beat-index-width localparam helpers;
  - state enum {EMPTY, EMIT}.
- One sub-module, int_lane_select: combinational; given held word, beat index and C, produces the LANES-wide zero-masked slice.
- The FSM, counters and handshake logic stay in the top module.

Test Plan (INT_WIDTH=4, IN_WIDTH=32, LANES=2 unless stated):
1. Full word: word 0x76543210, count 0, out_ready_i=1 -> four beats 0x10, 0x32, 0x54, 0x76; out_last_o only on 0x76; first beat one cycle after accept.
2. Partial word: word 0xFFFFF3A1, count 3 -> beats 0xA1, 0x03 (lane1 masked to 0); out_last_o on the second beat.
3. Backpressure: out_ready_i low for 5 cycles after beat 0 -> out_data_o holds 0x10 with out_valid_o=1; sequence resumes unchanged.
4. Back-to-back: two words held valid with out_ready_i=1 -> second word accepted on the last-beat cycle of the first; 8 contiguous beats, no idle cycle.
5. Flush and reset: assert flush_i during beat 1 -> out_valid_o=0 next cycle, in_ready_o=1. Separately, drop rst_ni asynchronously mid-beat -> outputs go to reset values immediately, and no stale beat appears after release.
6. INT_WIDTH=1, IN_WIDTH=8, LANES=1: word 0x05, count 4 -> beats 1, 0, 1, 0; out_last_o on the 4th beat.
